naval_board_ctrl: RTL and testbench

//  Parametrised board controller for the naval-battle game: stores a ROWSxCOLS ship map and attack map,

---
 rtl/naval_board_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_naval_board_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/naval_board_ctrl.sv
// naval_board_ctrl: board controller for the naval-battle game.
// Keeps the ship map and the attack map, moves a cursor, scores each shot
// as hit, miss or repeat, counts hits and shots, and detects game over.
// It also scans the LED matrix and drives the RGB shot indicator.
// Ports:
//   clk, clr_n          clock, asynchronous active-low reset
//   mode                00 idle, 01 place, 10 attack, 11 review
//   ship_map_in         preset ship map, bit r*COLS+c = (row r, col c)
//   btn_confirm/count   raw asynchronous buttons, active high
//   cur_row/cur_col     cursor position
//   hits/shots          ship cells hit / non-repeat shots (saturating)
//   rgb_output          [1] hit, [0] miss, 11 repeat shot
//   game_over, state_o  end-of-game flag and FSM state
//   m_col/m_line        one-hot column select / active-low row data
module naval_board_ctrl #(
  parameter int unsigned COLS     = 5,
  parameter int unsigned ROWS     = 7,
  parameter int unsigned SCAN_DIV = 1024,
  parameter int unsigned DEB_CYC  = 65536,
  parameter int unsigned BLINK_B  = 22,
  parameter int unsigned SHOT_W   = 8
) (
  input  logic                            clk,
  input  logic                            clr_n,
  input  logic [1:0]                      mode,
  input  logic [ROWS*COLS-1:0]            ship_map_in,
  input  logic                            btn_confirm,
  input  logic                            btn_count,
  output logic [$clog2(ROWS)-1:0]         cur_row,
  output logic [$clog2(COLS)-1:0]         cur_col,
  output logic [$clog2(ROWS*COLS+1)-1:0]  hits,
  output logic [SHOT_W-1:0]               shots,
  output logic [1:0]                      rgb_output,
  output logic                            game_over,
  output logic [1:0]                      state_o,
  output logic [COLS-1:0]                 m_col,
  output logic [ROWS-1:0]                 m_line
);

  localparam int unsigned NCELL = ROWS * COLS;
  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned HW    = $clog2(NCELL + 1);
  localparam int unsigned IW    = $clog2(NCELL);
  localparam int unsigned DW    = $clog2(DEB_CYC);
  localparam int unsigned SW    = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLACE = 2'b01,
    S_PLAY  = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t state_q, next_state;

  // Button conditioning: index 0 = confirm, index 1 = count
  logic [1:0]    raw;
  logic [1:0]    sync_a, sync_b, stable, pulse;
  logic [DW-1:0] deb_cnt [2];

  assign raw = {btn_count, btn_confirm};

  // Synchronise, then accept a new level only after DEB_CYC stable cycles;
  // the pulse fires once, on acceptance of a rising level.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_a     <= '0;
      sync_b     <= '0;
      stable     <= '0;
      pulse      <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      for (int i = 0; i < 2; i++) begin
        pulse[i] <= 1'b0;
        if (sync_b[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYC - 1)) begin
          stable[i]  <= sync_b[i];
          deb_cnt[i] <= '0;
          pulse[i]   <= sync_b[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Game data registers
  logic [NCELL-1:0] ship_q, attack_q;
  logic [HW-1:0]    ship_cnt_q, hits_q;
  logic [SHOT_W-1:0] shots_q;
  logic [1:0]       rgb_q;
  logic             loaded_q;
  logic [RW-1:0]    row_q;
  logic [CW-1:0]    col_q;
  logic             game_over_q;

  function automatic logic [HW-1:0] popcount(input logic [NCELL-1:0] v);
    logic [HW-1:0] n;
    n = '0;
    for (int i = 0; i < int'(NCELL); i++) n = n + HW'(v[i]);
    return n;
  endfunction

  // Next-state logic; mode 00 wins from every state
  always_comb begin
    next_state = state_q;
    if (mode == 2'b00) begin
      next_state = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (mode == 2'b01) next_state = S_PLACE;
        S_PLACE: if (mode == 2'b10 && loaded_q) next_state = S_PLAY;
        S_PLAY:  if (hits_q == ship_cnt_q) next_state = S_OVER;
        S_OVER:  next_state = S_OVER;
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= S_IDLE;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= next_state;
      game_over_q <= (next_state == S_OVER);
    end
  end

  // Shot and cursor qualifiers, and the linear index of the cursor cell
  logic          shot_fire, adv;
  logic [IW-1:0] cell_idx;

  always_comb begin
    shot_fire = pulse[0] && (state_q == S_PLAY) && (mode == 2'b10);
    adv       = pulse[1] && ((state_q == S_PLACE) ||
                             ((state_q == S_PLAY) && (mode != 2'b11)));
    cell_idx  = IW'(row_q) * IW'(COLS) + IW'(col_q);
  end

  // Maps, counters, cursor and indicator
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ship_q     <= '0;
      attack_q   <= '0;
      ship_cnt_q <= '0;
      hits_q     <= '0;
      shots_q    <= '0;
      rgb_q      <= 2'b00;
      loaded_q   <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
    end else if (mode == 2'b00) begin
      ship_q     <= '0;
      attack_q   <= '0;
      ship_cnt_q <= '0;
      hits_q     <= '0;
      shots_q    <= '0;
      rgb_q      <= 2'b00;
      loaded_q   <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      if ((state_q == S_PLACE) && pulse[0] && (ship_map_in != '0)) begin
        ship_q     <= ship_map_in;
        ship_cnt_q <= popcount(ship_map_in);
        loaded_q   <= 1'b1;
      end
      if (shot_fire) begin
        if (attack_q[cell_idx]) begin
          rgb_q <= 2'b11;
        end else begin
          attack_q[cell_idx] <= 1'b1;
          if (shots_q != '1) shots_q <= shots_q + SHOT_W'(1);
          if (ship_q[cell_idx]) begin
            rgb_q  <= 2'b10;
            hits_q <= hits_q + HW'(1);
          end else begin
            rgb_q <= 2'b01;
          end
        end
      end
      // Uses the pre-advance cursor above, so a simultaneous shot lands first
      if (adv) begin
        if (col_q == CW'(COLS - 1)) begin
          col_q <= '0;
          row_q <= (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

  // Matrix scan and blink prescalers
  logic [SW-1:0]    scan_cnt;
  logic [CW-1:0]    col_idx, col_nxt;
  logic [BLINK_B:0] blink_cnt;
  logic [NCELL-1:0] disp_c;
  logic [ROWS-1:0]  line_c;

  always_comb begin
    col_nxt = col_idx;
    if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      col_nxt = (col_idx == CW'(COLS - 1)) ? '0 : col_idx + CW'(1);
    end
  end

  // Display source per state; the cursor blinks only while playing
  always_comb begin
    disp_c = '0;
    case (state_q)
      S_PLACE: disp_c = ship_q;
      S_PLAY: begin
        disp_c           = attack_q;
        disp_c[cell_idx] = attack_q[cell_idx] ^ blink_cnt[BLINK_B];
      end
      S_OVER:  disp_c = ship_q | attack_q;
      default: disp_c = '0;
    endcase
    line_c = '1;
    for (int r = 0; r < int'(ROWS); r++) begin
      line_c[r] = ~disp_c[IW'(r) * IW'(COLS) + IW'(col_nxt)];
    end
  end

  // m_col and m_line load from the same next index so they move together
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      scan_cnt  <= '0;
      col_idx   <= '0;
      blink_cnt <= '0;
      m_col     <= COLS'(1);
      m_line    <= '1;
    end else begin
      scan_cnt  <= (scan_cnt == SW'(SCAN_DIV - 1)) ? '0 : scan_cnt + SW'(1);
      col_idx   <= col_nxt;
      blink_cnt <= blink_cnt + (BLINK_B + 1)'(1);
      m_col     <= COLS'(1) << col_nxt;
      m_line    <= line_c;
    end
  end

  assign cur_row    = row_q;
  assign cur_col    = col_q;
  assign hits       = hits_q;
  assign shots      = shots_q;
  assign rgb_output = rgb_q;
  assign game_over  = game_over_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_naval_board_ctrl.sv
// Directed bench for naval_board_ctrl with a 5x7 board, short debounce and scan.
module tb_naval_board_ctrl;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [1:0]  mode;
  logic [34:0] ship_map_in;
  logic        btn_confirm, btn_count;
  logic [2:0]  cur_row, cur_col;
  logic [5:0]  hits;
  logic [7:0]  shots;
  logic [1:0]  rgb_output;
  logic        game_over;
  logic [1:0]  state_o;
  logic [4:0]  m_col;
  logic [6:0]  m_line;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  naval_board_ctrl #(
    .COLS(5), .ROWS(7), .SCAN_DIV(4), .DEB_CYC(4), .BLINK_B(22), .SHOT_W(8)
  ) dut (
    .clk(clk), .clr_n(clr_n), .mode(mode), .ship_map_in(ship_map_in),
    .btn_confirm(btn_confirm), .btn_count(btn_count),
    .cur_row(cur_row), .cur_col(cur_col), .hits(hits), .shots(shots),
    .rgb_output(rgb_output), .game_over(game_over), .state_o(state_o),
    .m_col(m_col), .m_line(m_line)
  );

  typedef struct {
    int          mode;
    logic [34:0] map;
    int          glitch;
    int          n_adv;
    int          cnf;
    int          e_row, e_col, e_hits, e_shots, e_rgb, e_go, e_st;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold a button long enough to be accepted, then release long enough to settle
  task automatic press(input int which);
    @(negedge clk);
    if (which == 0) btn_confirm = 1'b1; else btn_count = 1'b1;
    cycles(10);
    btn_confirm = 1'b0;
    btn_count   = 1'b0;
    cycles(12);
  endtask

  task automatic check_all(input int idx, input vec_t v);
    chk($sformatf("v%0d_row", idx), int'(cur_row), v.e_row);
    chk($sformatf("v%0d_col", idx), int'(cur_col), v.e_col);
    chk($sformatf("v%0d_hits", idx), int'(hits), v.e_hits);
    chk($sformatf("v%0d_shots", idx), int'(shots), v.e_shots);
    chk($sformatf("v%0d_rgb", idx), int'(rgb_output), v.e_rgb);
    chk($sformatf("v%0d_go", idx), int'(game_over), v.e_go);
    chk($sformatf("v%0d_state", idx), int'(state_o), v.e_st);
  endtask

  initial begin
    logic [4:0] prev, nxt;
    logic [6:0] exp_line;
    int run;
    bit seen;
    bit found;

    //         mode map     gl adv cnf  row col hit sht rgb go st
    vecs[0]  = '{0, 35'h0,  0, 0,  0,   0,  0,  0,  0,  0,  0, 0};
    vecs[1]  = '{1, 35'h0,  0, 0,  0,   0,  0,  0,  0,  0,  0, 1};
    vecs[2]  = '{1, 35'h0,  1, 0,  0,   0,  0,  0,  0,  0,  0, 1};
    vecs[3]  = '{1, 35'h0,  0, 1,  0,   0,  1,  0,  0,  0,  0, 1};
    vecs[4]  = '{0, 35'h0,  0, 0,  0,   0,  0,  0,  0,  0,  0, 0};
    vecs[5]  = '{1, 35'h0,  0, 0,  1,   0,  0,  0,  0,  0,  0, 1};
    vecs[6]  = '{2, 35'h0,  0, 0,  0,   0,  0,  0,  0,  0,  0, 1};
    vecs[7]  = '{1, 35'h41, 0, 0,  1,   0,  0,  0,  0,  0,  0, 1};
    vecs[8]  = '{2, 35'h41, 0, 0,  0,   0,  0,  0,  0,  0,  0, 2};
    vecs[9]  = '{2, 35'h41, 0, 0,  1,   0,  0,  1,  1,  2,  0, 2};
    vecs[10] = '{2, 35'h41, 0, 1,  1,   0,  1,  1,  2,  1,  0, 2};
    vecs[11] = '{2, 35'h41, 0, 34, 1,   0,  0,  1,  2,  3,  0, 2};
    vecs[12] = '{3, 35'h41, 0, 0,  1,   0,  0,  1,  2,  3,  0, 2};
    vecs[13] = '{2, 35'h41, 0, 6,  1,   1,  1,  2,  3,  2,  1, 3};
    vecs[14] = '{2, 35'h41, 0, 1,  1,   1,  1,  2,  3,  2,  1, 3};
    vecs[15] = '{0, 35'h41, 0, 0,  0,   0,  0,  0,  0,  0,  0, 0};

    clr_n = 1'b0; mode = 2'b00; ship_map_in = '0;
    btn_confirm = 1'b0; btn_count = 1'b0;
    cycles(3);
    chk("rst_mcol", int'(m_col), 1);
    chk("rst_mline", int'(m_line), 127);
    chk("rst_state", int'(state_o), 0);
    clr_n = 1'b1;
    cycles(2);

    for (int i = 0; i < 16; i++) begin
      mode        = 2'(vecs[i].mode);
      ship_map_in = vecs[i].map;
      cycles(4);
      if (vecs[i].glitch != 0) begin
        btn_count = 1'b1;
        cycles(2);
        btn_count = 1'b0;
        cycles(12);
      end
      for (int k = 0; k < vecs[i].n_adv; k++) press(1);
      if (vecs[i].cnf != 0) press(0);
      cycles(4);
      check_all(i, vecs[i]);
    end

    // Cursor wrap over the whole board
    mode = 2'b01;
    cycles(4);
    for (int k = 1; k <= 35; k++) begin
      press(1);
      if (k == 5) begin
        chk("wrap5_row", int'(cur_row), 1);
        chk("wrap5_col", int'(cur_col), 0);
      end
    end
    chk("wrap35_row", int'(cur_row), 0);
    chk("wrap35_col", int'(cur_col), 0);

    // Column scan in PLACE with only cell (0,0) set
    ship_map_in = 35'h1;
    press(0);
    prev = m_col;
    run  = 0;
    seen = 1'b0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      exp_line = (m_col == 5'b00001) ? 7'h7E : 7'h7F;
      chk("scan_line", int'(m_line), int'(exp_line));
      if (m_col != prev) begin
        nxt = {prev[3:0], prev[4]};
        chk("scan_next", int'(m_col), int'(nxt));
        if (seen) chk("scan_period", run, 4);
        seen = 1'b1;
        prev = m_col;
        run  = 1;
      end else begin
        run++;
      end
    end

    // Asynchronous reset in the middle of a scan
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (m_col == 5'b00100) found = 1'b1;
    end
    chk("scan_reach_col2", int'(found), 1);
    #2 clr_n = 1'b0;
    #1;
    chk("arst_mcol", int'(m_col), 1);
    chk("arst_mline", int'(m_line), 127);
    chk("arst_state", int'(state_o), 0);
    chk("arst_col", int'(cur_col), 0);
    cycles(2);
    clr_n = 1'b1;
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
